// File: rtl/fsk_pkg.sv
// fsk_pkg: shared state type, default parameters and counter-width helpers for the FSK transmit path
package fsk_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_GAP} fsk_tx_state_t;
  localparam int DEF_BIT_CYCLES = 16;
  localparam int DEF_PREAMBLE_BITS = 8;
  localparam int DEF_GAP_BITS = 2;
  localparam int DEF_WORD_W = 7;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/fsk_bit_timer.sv
// fsk_bit_timer: cycle-within-bit and bit-within-state counters with a bit_end strobe
// Ports: clk, reset (async, active high), clear (zero both counters),
//        bit_end (last cycle of the current bit period), bit_cnt (bit index in state).
module fsk_bit_timer import fsk_pkg::*; #(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int BW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic          bit_end,
  output logic [BW-1:0] bit_cnt
);
  localparam int CW = cnt_w(BIT_CYCLES);
  logic [CW-1:0] cyc_cnt_q;
  logic [BW-1:0] bit_cnt_q;
  assign bit_end = cyc_cnt_q == CW'(BIT_CYCLES - 1);
  assign bit_cnt = bit_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (clear) begin
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= bit_end ? '0 : cyc_cnt_q + 1'b1;
      bit_cnt_q <= bit_cnt_q + BW'(bit_end);
    end
  end
endmodule

// File: rtl/fsk_tx_sequencer.sv
// fsk_tx_sequencer: frames Hamming codewords into preamble/data/gap bit streams for the FSK encoder
// Ports: clk, reset (async, active high); word_in/word_last/word_valid/word_ready handshake in;
//        sending/codein to the encoder; busy status; frame_done/underrun one-cycle pulses.
module fsk_tx_sequencer import fsk_pkg::*; #(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter int GAP_BITS = DEF_GAP_BITS,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_last,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              sending,
  output logic              codein,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int BW = cnt_w(max3(PREAMBLE_BITS, WORD_W, GAP_BITS));
  localparam int IW = cnt_w(WORD_W);
  localparam logic [BW-1:0] PRE_END = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] WORD_END = BW'(WORD_W - 1);
  localparam logic [BW-1:0] GAP_END = BW'(GAP_BITS - 1);
  fsk_tx_state_t state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic last_q, last_d;
  logic sending_q, sending_d, codein_q, codein_d;
  logic frame_done_q, frame_done_d, underrun_q, underrun_d;
  logic bit_end, clear, restart, word_end;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [IW-1:0] idx;
  fsk_bit_timer #(.BIT_CYCLES(BIT_CYCLES), .BW(BW)) u_timer (
    .clk(clk), .reset(reset), .clear(clear), .bit_end(bit_end), .bit_cnt(bit_cnt)
  );
  assign word_end = state_q == ST_DATA && bit_end && bit_cnt == WORD_END;
  assign word_ready = state_q == ST_IDLE || (word_end && !last_q);
  assign busy = state_q != ST_IDLE;
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    last_d = last_q;
    restart = 1'b0;
    frame_done_d = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: if (word_valid) begin
        state_d = ST_PREAMBLE;
        word_d = word_in;
        last_d = word_last;
      end
      ST_PREAMBLE: if (bit_end && bit_cnt == PRE_END) state_d = ST_DATA;
      ST_DATA: if (word_end) begin
        if (last_q) begin
          frame_done_d = 1'b1;
          state_d = ST_GAP;
        end else if (word_valid) begin
          word_d = word_in;
          last_d = word_last;
          restart = 1'b1;
        end else begin
          underrun_d = 1'b1;
          state_d = ST_GAP;
        end
      end
      default: if (bit_end && bit_cnt == GAP_END) state_d = ST_IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they line up with the state they describe.
  assign clear = state_q == ST_IDLE || state_d != state_q || restart;
  assign bit_nxt = clear ? '0 : bit_cnt + BW'(bit_end);
  assign idx = IW'(WORD_W - 1) - IW'(bit_nxt);
  assign sending_d = state_d == ST_PREAMBLE || state_d == ST_DATA;
  assign codein_d = state_d == ST_PREAMBLE ? ~bit_nxt[0] : state_d == ST_DATA ? word_d[idx] : 1'b0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q <= '0;
      last_q <= 1'b0;
      sending_q <= 1'b0;
      codein_q <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      last_q <= last_d;
      sending_q <= sending_d;
      codein_q <= codein_d;
      frame_done_q <= frame_done_d;
      underrun_q <= underrun_d;
    end
  end
  assign sending = sending_q;
  assign codein = codein_q;
  assign frame_done = frame_done_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// tb_fsk_tx_sequencer: directed frame checks against a cycle model for default and swept parameters
module tb_fsk_tx_sequencer;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
  logic [6:0] word_in = '0;
  logic word_last = 1'b0, word_valid = 1'b0;
  logic v1, v2;
  logic r1, s1, c1, b1, f1, u1, r2, s2, c2, b2, f2, u2;
  logic o_ready, o_send, o_code, o_busy, o_done, o_under;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign v1 = word_valid & ~sel;
  assign v2 = word_valid & sel;
  fsk_tx_sequencer dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_last(word_last), .word_valid(v1),
    .word_ready(r1), .sending(s1), .codein(c1), .busy(b1), .frame_done(f1), .underrun(u1)
  );
  fsk_tx_sequencer #(.BIT_CYCLES(32), .PREAMBLE_BITS(1), .GAP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .word_in(word_in), .word_last(word_last), .word_valid(v2),
    .word_ready(r2), .sending(s2), .codein(c2), .busy(b2), .frame_done(f2), .underrun(u2)
  );
  assign o_ready = sel ? r2 : r1;
  assign o_send = sel ? s2 : s1;
  assign o_code = sel ? c2 : c1;
  assign o_busy = sel ? b2 : b1;
  assign o_done = sel ? f2 : f1;
  assign o_under = sel ? u2 : u1;
  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Plays one frame starting in the current (idle) cycle T and checks every output each cycle
  // until the first IDLE cycle after the gap; returns in that cycle without advancing.
  task automatic play(input logic s, input logic [6:0] w0, input logic [6:0] w1,
                      input int nw, input bit under, input bit tog);
    int bc, pb, gb, h, slen, glen, k, j;
    logic [6:0] ws;
    logic first_last, e_code;
    sel = s;
    bc = s ? 32 : 16;
    pb = s ? 1 : 8;
    gb = s ? 1 : 2;
    h = (pb + 7) * bc;
    slen = (pb + 7 * nw) * bc;
    glen = gb * bc;
    first_last = nw == 1 && !under;
    word_in = w0;
    word_last = first_last;
    word_valid = 1'b1;
    check("idle_ready", o_ready, 1'b1);
    check("idle_sending", o_send, 1'b0);
    check("idle_busy", o_busy, 1'b0);
    for (int t = 1; t <= slen + glen + 1; t++) begin
      tick();
      if (tog) begin
        word_valid = t[0];
        word_in = 7'h55;
        word_last = 1'b0;
      end else if (nw == 2) begin
        word_valid = 1'b1;
        if (t >= h) begin
          word_in = w1;
          word_last = 1'b1;
        end
      end else word_valid = 1'b0;
      k = (t - 1) / bc;
      j = k - pb;
      ws = (j / 7 == 0) ? w0 : w1;
      e_code = t > slen ? 1'b0 : k < pb ? (k % 2 == 0) : ws[6 - (j % 7)];
      check("sending", o_send, t <= slen);
      check("codein", o_code, e_code);
      check("busy", o_busy, t <= slen + glen);
      check("frame_done", o_done, t == slen + 1 && !under);
      check("underrun", o_under, t == slen + 1 && under);
      check("word_ready", o_ready, (t == h && !first_last) || t == slen + glen + 1);
    end
    word_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_sending", s1, 1'b0);
    check("rst_codein", c1, 1'b0);
    check("rst_busy", b1, 1'b0);
    check("rst_done", f1, 1'b0);
    check("rst_under", u1, 1'b0);
    check("rst_ready", r1, 1'b1);
    word_valid = 1'b1;
    tick();
    check("rst_no_accept", b1, 1'b0);
    word_valid = 1'b0;
    reset = 1'b0;
    tick();
    play(1'b0, 7'b1011010, 7'b0, 1, 1'b0, 1'b0);
    play(1'b0, 7'b1111111, 7'b0000001, 2, 1'b0, 1'b0);
    play(1'b0, 7'b1100110, 7'b0, 1, 1'b1, 1'b0);
    word_in = 7'b1010101;
    word_last = 1'b1;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    repeat (179) tick();
    check("mid_sending", s1, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_sending", s1, 1'b0);
    check("rst_mid_codein", c1, 1'b0);
    check("rst_mid_busy", b1, 1'b0);
    check("rst_mid_done", f1, 1'b0);
    check("rst_mid_under", u1, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rel_ready", r1, 1'b1);
    check("rel_busy", b1, 1'b0);
    tick();
    play(1'b0, 7'b0011100, 7'b0, 1, 1'b0, 1'b0);
    play(1'b0, 7'b0110011, 7'b0, 1, 1'b0, 1'b1);
    play(1'b0, 7'b1001001, 7'b0, 1, 1'b0, 1'b0);
    play(1'b1, 7'b1000001, 7'b0, 1, 1'b0, 1'b0);
    play(1'b1, 7'b0111110, 7'b0, 1, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
